// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, widths and helpers for the VGA pixel-coordinate source.
package vga_timing_pkg;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FP      = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BP      = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FP      = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BP      = 33;

    localparam int unsigned H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int unsigned COORD_W     = 10;
    localparam int unsigned FRAME_CNT_W = 16;

    typedef logic [COORD_W-1:0] coord_t;

    // True when lo <= c < lo+len.
    function automatic logic in_window(coord_t c, int unsigned lo, int unsigned len);
        return (32'(c) >= lo) && (32'(c) < lo + len);
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// N-stage 2-bit shift register with async preset to 1; N=0 is a plain passthrough.
module vga_sync_delay
    import vga_timing_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] d_i,
    output logic [1:0] q_o
);

    generate
        if (N == 0) begin : g_pass
            assign q_o = d_i;
        end else begin : g_pipe
            logic [1:0] stage_q [N];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int unsigned i = 0; i < N; i++) stage_q[i] <= '1;
                end else begin
                    stage_q[0] <= d_i;
                    for (int unsigned i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign q_o = stage_q[N-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing source: free-running counters, delayed syncs, frame pulse/counter.
// Optional vertical-blank interrupt enabled by defining VGA_VBLANK_IRQ_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter int unsigned SYNC_DELAY = 2
) (
    input  logic                   vga_clk,
    input  logic                   reset,
    input  logic                   irq_ack,
    output logic [9:0]             DrawX,
    output logic [9:0]             DrawY,
    output logic                   blank,
    output logic                   hs,
    output logic                   vs,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   irq
);

    localparam int unsigned LINE_LEN    = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned FRAME_LINES = V_VISIBLE + V_FP + V_SYNC + V_BP;

    coord_t                 hc_q, hc_d;
    coord_t                 vc_q, vc_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   h_last, v_last;
    logic                   hs_raw, vs_raw;
    logic [1:0]             sync_dly;

    always_comb begin
        h_last      = (hc_q == coord_t'(LINE_LEN - 1));
        v_last      = (vc_q == coord_t'(FRAME_LINES - 1));
        hc_d        = h_last ? '0 : hc_q + coord_t'(1);
        vc_d        = vc_q;
        frame_cnt_d = frame_cnt_q;
        if (h_last) begin
            vc_d = v_last ? '0 : vc_q + coord_t'(1);
            if (v_last) frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hc_q        <= '0;
            vc_q        <= '0;
            frame_cnt_q <= '0;
        end else begin
            hc_q        <= hc_d;
            vc_q        <= vc_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign hs_raw = !in_window(hc_q, H_VISIBLE + H_FP, H_SYNC);
    assign vs_raw = !in_window(vc_q, V_VISIBLE + V_FP, V_SYNC);

    // Only the syncs are delayed; blank/frame_start stay aligned to the counters.
    vga_sync_delay #(
        .N(SYNC_DELAY)
    ) u_sync_delay (
        .clk_i (vga_clk),
        .rst_i (reset),
        .d_i   ({hs_raw, vs_raw}),
        .q_o   (sync_dly)
    );

    assign hs          = sync_dly[1];
    assign vs          = sync_dly[0];
    assign DrawX       = hc_q;
    assign DrawY       = vc_q;
    assign blank       = !reset && (32'(hc_q) < H_VISIBLE) && (32'(vc_q) < V_VISIBLE);
    assign frame_start = !reset && (hc_q == '0) && (vc_q == '0);
    assign frame_count = frame_cnt_q;

`ifdef VGA_VBLANK_IRQ_EN
    logic irq_q, irq_d, irq_set;

    assign irq_set = (hc_q == '0) && (32'(vc_q) == V_VISIBLE);

    always_comb begin
        irq_d = irq_q;
        if (irq_set)      irq_d = 1'b1;
        else if (irq_ack) irq_d = 1'b0;
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end

    assign irq = irq_q;
`else
    logic unused_irq_ack;
    assign unused_irq_ack = irq_ack;
    assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a reduced raster (32 x 12, 384 clocks per frame).
module tb_vga_timing_gen;

    localparam int unsigned T_HV = 16, T_HFP = 4, T_HS = 6, T_HBP = 6;
    localparam int unsigned T_VV = 6,  T_VFP = 2, T_VS = 2, T_VBP = 2;

    localparam int F_DX = 0, F_DY = 1, F_BLANK = 2, F_HS = 3, F_VS = 4, F_FS = 5, F_FC = 6,
                   F_IRQ = 7, F_HSRUN = 8, F_HSPER = 9, F_VSRUN = 10, F_FSPER = 11,
                   F_BLFRM = 12, F_BLRUN = 13, F_HS0 = 14;

`ifdef VGA_VBLANK_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        vga_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        irq_ack = 1'b0;
    logic [9:0]  DrawX, DrawY;
    logic        blank, hs, vs, frame_start, irq;
    logic [15:0] frame_count;
    logic [9:0]  d0_x, d0_y;
    logic        d0_blank, d0_hs, d0_vs, d0_fs, d0_irq;
    logic [15:0] d0_fc;

    vga_timing_gen #(
        .H_VISIBLE(T_HV), .H_FP(T_HFP), .H_SYNC(T_HS), .H_BP(T_HBP),
        .V_VISIBLE(T_VV), .V_FP(T_VFP), .V_SYNC(T_VS), .V_BP(T_VBP),
        .SYNC_DELAY(2)
    ) dut (
        .vga_clk(vga_clk), .reset(reset), .irq_ack(irq_ack),
        .DrawX(DrawX), .DrawY(DrawY), .blank(blank), .hs(hs), .vs(vs),
        .frame_start(frame_start), .frame_count(frame_count), .irq(irq)
    );

    vga_timing_gen #(
        .H_VISIBLE(T_HV), .H_FP(T_HFP), .H_SYNC(T_HS), .H_BP(T_HBP),
        .V_VISIBLE(T_VV), .V_FP(T_VFP), .V_SYNC(T_VS), .V_BP(T_VBP),
        .SYNC_DELAY(0)
    ) dut0 (
        .vga_clk(vga_clk), .reset(reset), .irq_ack(irq_ack),
        .DrawX(d0_x), .DrawY(d0_y), .blank(d0_blank), .hs(d0_hs), .vs(d0_vs),
        .frame_start(d0_fs), .frame_count(d0_fc), .irq(d0_irq)
    );

    always #5 vga_clk = ~vga_clk;

    // Bench cycle index: clocks since the last reset release.
    int k = 0;
    always @(posedge vga_clk or posedge reset) begin
        if (reset) k <= 0;
        else       k <= k + 1;
    end

    typedef struct {
        int          kk;
        int          fid;
        logic [31:0] exp;
        string       name;
    } sb_entry_t;

    sb_entry_t sb[$];
    int n_vec = 0;
    int n_err = 0;

    int hs_run, hs_lowrun, hs_fall_k, hs_period, vs_run, vs_lowrun;
    int fs_k, fs_period, blank_acc, blank_frame, blank_run, blank_linerun;
    logic prev_hs, prev_vs, prev_blank;

    function automatic void expect_at(int kk, int fid, logic [31:0] v, string nm);
        sb_entry_t e;
        e.kk = kk; e.fid = fid; e.exp = v; e.name = nm;
        sb.push_back(e);
    endfunction

    function automatic logic [31:0] actual(int fid);
        case (fid)
            F_DX:    return 32'(DrawX);
            F_DY:    return 32'(DrawY);
            F_BLANK: return 32'(blank);
            F_HS:    return 32'(hs);
            F_VS:    return 32'(vs);
            F_FS:    return 32'(frame_start);
            F_FC:    return 32'(frame_count);
            F_IRQ:   return 32'(irq);
            F_HSRUN: return 32'(hs_lowrun);
            F_HSPER: return 32'(hs_period);
            F_VSRUN: return 32'(vs_lowrun);
            F_FSPER: return 32'(fs_period);
            F_BLFRM: return 32'(blank_frame);
            F_BLRUN: return 32'(blank_linerun);
            F_HS0:   return 32'(d0_hs);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic void compare(sb_entry_t e);
        logic [31:0] a;
        a = actual(e.fid);
        n_vec++;
        if (a !== e.exp) begin
            n_err++;
            $display("FAIL %s @k=%0d: got 0x%0h, expected 0x%0h", e.name, e.kk, a, e.exp);
        end
    endfunction

    function automatic void clear_meas();
        hs_run = 0; hs_lowrun = 0; hs_fall_k = -1; hs_period = 0;
        vs_run = 0; vs_lowrun = 0;
        fs_k = -1; fs_period = 0; blank_acc = 0; blank_frame = 0;
        blank_run = 0; blank_linerun = 0;
        prev_hs = 1'b1; prev_vs = 1'b1; prev_blank = 1'b0;
    endfunction

    // Monitor: measures run lengths/periods and pops due scoreboard entries each cycle.
    initial begin
        sb_entry_t e;
        clear_meas();
        forever begin
            @(negedge vga_clk);
            if (reset) begin
                clear_meas();
                while (sb.size() > 0 && sb[0].kk == -1) begin
                    e = sb.pop_front();
                    compare(e);
                end
            end else begin
                if (!hs) begin
                    if (prev_hs) begin
                        if (hs_fall_k >= 0) hs_period = k - hs_fall_k;
                        hs_fall_k = k;
                    end
                    hs_run++;
                end else if (!prev_hs) begin
                    hs_lowrun = hs_run;
                    hs_run = 0;
                end
                prev_hs = hs;
                if (!vs) vs_run++;
                else if (!prev_vs) begin
                    vs_lowrun = vs_run;
                    vs_run = 0;
                end
                prev_vs = vs;
                if (blank) blank_run++;
                else if (prev_blank) begin
                    blank_linerun = blank_run;
                    blank_run = 0;
                end
                prev_blank = blank;
                if (frame_start) begin
                    if (fs_k >= 0) fs_period = k - fs_k;
                    fs_k = k;
                    blank_frame = blank_acc;
                    blank_acc = 0;
                end
                if (blank) blank_acc++;
                while (sb.size() > 0 && sb[0].kk >= 0 && sb[0].kk <= k) begin
                    e = sb.pop_front();
                    if (e.kk < k) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL %s: check for k=%0d missed (now k=%0d), expected 0x%0h",
                                 e.name, e.kk, k, e.exp);
                    end else begin
                        compare(e);
                    end
                end
            end
        end
    end

    task automatic wait_until(int target);
        while (k < target) @(negedge vga_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        // Reset-state expectations.
        expect_at(-1, F_DX, 0, "rst_drawx");   expect_at(-1, F_DY, 0, "rst_drawy");
        expect_at(-1, F_BLANK, 0, "rst_blank"); expect_at(-1, F_HS, 1, "rst_hs");
        expect_at(-1, F_VS, 1, "rst_vs");       expect_at(-1, F_FS, 0, "rst_fs");
        expect_at(-1, F_FC, 0, "rst_fc");       expect_at(-1, F_IRQ, 0, "rst_irq");
        expect_at(-1, F_HS0, 1, "rst_hs_nodelay");
        // First cycle after release.
        expect_at(0, F_DX, 0, "first_drawx");   expect_at(0, F_DY, 0, "first_drawy");
        expect_at(0, F_BLANK, 1, "first_blank"); expect_at(0, F_FS, 1, "first_fs");
        expect_at(0, F_FC, 0, "first_fc");      expect_at(0, F_HS, 1, "first_hs");
        expect_at(0, F_VS, 1, "first_vs");
        // Line timing.
        expect_at(16, F_BLANK, 0, "blank_end_of_visible");
        expect_at(16, F_BLRUN, 16, "blank_run_len");
        expect_at(19, F_HS0, 1, "hs_nodelay_before");
        expect_at(20, F_HS0, 0, "hs_nodelay_start");
        expect_at(21, F_HS, 1, "hs_delayed_before");
        expect_at(22, F_HS, 0, "hs_delayed_start");
        expect_at(28, F_HS, 1, "hs_delayed_end");
        expect_at(28, F_HSRUN, 6, "hs_low_len");
        expect_at(54, F_HSPER, 32, "hs_period");
        // Vertical blank entry and vsync.
        expect_at(192, F_DX, 0, "vblank_drawx");
        expect_at(192, F_DY, 6, "vblank_drawy");
        expect_at(192, F_IRQ, 0, "irq_before_set");
        expect_at(193, F_IRQ, 32'(IRQ_ON), "irq_set");
        expect_at(257, F_VS, 1, "vs_before");
        expect_at(258, F_VS, 0, "vs_start");
        expect_at(321, F_VS, 0, "vs_last_low");
        expect_at(322, F_VS, 1, "vs_end");
        expect_at(322, F_VSRUN, 64, "vs_low_len");
        // Frame boundary.
        expect_at(383, F_DX, 31, "last_drawx"); expect_at(383, F_DY, 11, "last_drawy");
        expect_at(383, F_FC, 0, "fc_before_wrap");
        expect_at(384, F_DX, 0, "wrap_drawx");  expect_at(384, F_DY, 0, "wrap_drawy");
        expect_at(384, F_FS, 1, "fs_frame1");   expect_at(384, F_FC, 1, "fc_frame1");
        expect_at(384, F_FSPER, 384, "fs_period");
        expect_at(384, F_BLFRM, 96, "blank_per_frame");
        expect_at(400, F_IRQ, 32'(IRQ_ON), "irq_held_unacked");
        expect_at(768, F_FC, 2, "fc_frame2");
        expect_at(768, F_FSPER, 384, "fs_period2");
        expect_at(800, F_IRQ, 32'(IRQ_ON), "irq_before_ack");
        expect_at(801, F_IRQ, 0, "irq_acked");
        expect_at(961, F_IRQ, 32'(IRQ_ON), "irq_set_beats_ack");
        expect_at(962, F_IRQ, 0, "irq_ack_after_set");
        // Frame counter wrap.
        expect_at(1100, F_FC, 32'hFFFF, "fc_preloaded");
        expect_at(1151, F_FC, 32'hFFFF, "fc_before_16b_wrap");
        expect_at(1152, F_FC, 0, "fc_16b_wrap");
        // Mid-frame reset.
        expect_at(1396, F_DX, 20, "mid_drawx");  expect_at(1396, F_DY, 7, "mid_drawy");
        expect_at(-1, F_DX, 0, "midrst_drawx");  expect_at(-1, F_DY, 0, "midrst_drawy");
        expect_at(-1, F_HS, 1, "midrst_hs");     expect_at(-1, F_VS, 1, "midrst_vs");
        expect_at(-1, F_BLANK, 0, "midrst_blank"); expect_at(-1, F_FS, 0, "midrst_fs");
        expect_at(-1, F_IRQ, 0, "midrst_irq");   expect_at(-1, F_FC, 0, "midrst_fc");
        expect_at(0, F_DX, 0, "rerel_drawx");    expect_at(0, F_BLANK, 1, "rerel_blank");
        expect_at(0, F_FS, 1, "rerel_fs");       expect_at(0, F_FC, 0, "rerel_fc");
        expect_at(5, F_DX, 5, "rerel_run");

        reset = 1'b1;
        repeat (10) @(posedge vga_clk);
        #2 reset = 1'b0;

        wait_until(800);  irq_ack = 1'b1;
        wait_until(801);  irq_ack = 1'b0;
        wait_until(955);  irq_ack = 1'b1;
        wait_until(962);  irq_ack = 1'b0;

        wait_until(1000); force dut.frame_cnt_q = 16'hFFFF;
        wait_until(1001); release dut.frame_cnt_q;

        wait_until(1396);
        @(posedge vga_clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge vga_clk);
        #2 reset = 1'b0;

        guard = 0;
        while (sb.size() > 0 && guard < 2000) begin
            @(negedge vga_clk);
            guard++;
        end
        while (sb.size() > 0) begin
            sb_entry_t e;
            e = sb.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL %s: never checked, expected 0x%0h at k=%0d", e.name, e.exp, e.kk);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
